// File: rtl/vu_level_tracker_if.sv
// Sample/level bus between the UART receive path and the VU bar renderer.
// master drives samples and frame ticks, slave (the tracker) returns the bar state.
interface vu_level_tracker_if #(
  parameter int NUM_SEGS = 8
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                tick;
  logic [7:0]          level;
  logic [7:0]          peak;
  logic [NUM_SEGS-1:0] segs;
  logic                peak_stb;

  modport master (
    output rx_data, rx_valid, tick,
    input  level, peak, segs, peak_stb
  );

  modport slave (
    input  rx_data, rx_valid, tick,
    output level, peak, segs, peak_stb
  );
endinterface

// File: rtl/vu_level_tracker.sv
// VU bar level / peak-hold / thermometer tracker; VU_SIGNED_INPUT_EN selects signed-sample input.
// All outputs registered, 1-cycle latency; no backpressure, every rx_valid and tick is consumed.
module vu_level_tracker #(
  parameter int DECAY_STEP = 4,
  parameter int PEAK_STEP  = 2,
  parameter int HOLD_TICKS = 30,
  parameter int NUM_SEGS   = 8
) (
  input  logic               clk,
  input  logic               rst,
  vu_level_tracker_if.slave  bus
);
  localparam logic [7:0] DSTEP     = 8'(DECAY_STEP);
  localparam logic [7:0] PSTEP     = 8'(PEAK_STEP);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);
  localparam int         SEG_W     = 256 / NUM_SEGS;

  typedef enum logic [1:0] {IDLE, HOLD, FALL} pstate_t;

  pstate_t             state;
  logic [7:0]          level_q;
  logic [7:0]          peak_q;
  logic [7:0]          hold_cnt;
  logic [NUM_SEGS-1:0] segs_q;
  logic                stb_q;

  logic [7:0]          samp;
  logic [7:0]          decayed;
  logic [7:0]          level_next;
  logic [7:0]          peak_dec;
  logic [7:0]          peak_fall;
  logic [NUM_SEGS-1:0] segs_next;
  logic                capture;

`ifdef VU_SIGNED_INPUT_EN
  logic [7:0] mag;
  logic [6:0] mag_sat;

  // 0x80 has magnitude 128, which clamps to 127 so full-scale maps to 0xFE
  always_comb begin
    mag     = bus.rx_data[7] ? ((~bus.rx_data) + 8'd1) : bus.rx_data;
    mag_sat = mag[7] ? 7'h7F : mag[6:0];
    samp    = bus.rx_valid ? {mag_sat, 1'b0} : 8'd0;
  end
`else
  always_comb begin
    samp = bus.rx_valid ? bus.rx_data : 8'd0;
  end
`endif

  always_comb begin
    decayed = level_q;
    if (bus.tick) begin
      decayed = (level_q > DSTEP) ? (level_q - DSTEP) : 8'd0;
    end
    level_next = (decayed > samp) ? decayed : samp;

    capture   = bus.rx_valid && (samp >= peak_q) && (samp != 8'd0);
    peak_dec  = (peak_q > PSTEP) ? (peak_q - PSTEP) : 8'd0;
    peak_fall = (peak_dec > level_next) ? peak_dec : level_next;

    segs_next = '0;
    for (int i = 0; i < NUM_SEGS; i++) begin
      segs_next[i] = ({1'b0, level_next} > 9'(i * SEG_W));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      level_q  <= 8'd0;
      peak_q   <= 8'd0;
      hold_cnt <= 8'd0;
      segs_q   <= '0;
      stb_q    <= 1'b0;
    end else begin
      level_q <= level_next;
      segs_q  <= segs_next;
      stb_q   <= capture;
      // A capture overrides whatever the tick would have done this cycle
      if (capture) begin
        peak_q   <= samp;
        hold_cnt <= HOLD_INIT;
        state    <= HOLD;
      end else begin
        case (state)
          IDLE: peak_q <= level_next;
          HOLD: begin
            if (bus.tick) begin
              if (hold_cnt == 8'd1) begin
                hold_cnt <= 8'd0;
                state    <= FALL;
              end else begin
                hold_cnt <= hold_cnt - 8'd1;
              end
            end
          end
          FALL: begin
            if (bus.tick) begin
              peak_q <= peak_fall;
              if ((peak_fall == level_next) && (level_next == 8'd0)) begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.level    = level_q;
  assign bus.peak     = peak_q;
  assign bus.segs     = segs_q;
  assign bus.peak_stb = stb_q;
endmodule

// File: tb/tb_vu_level_tracker.sv
// Randomized and directed bench for vu_level_tracker against a behavioural model.
module tb_vu_level_tracker;
  localparam int NS    = 8;
  localparam int DEC   = 4;
  localparam int PST   = 2;
  localparam int HOLDT = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  vu_level_tracker_if #(.NUM_SEGS(NS)) bus ();

  vu_level_tracker #(
    .DECAY_STEP(DEC), .PEAK_STEP(PST), .HOLD_TICKS(HOLDT), .NUM_SEGS(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, following the behavioural rules directly
  int m_level, m_peak, m_hold_left, m_stb;
  bit m_holding, m_falling;

  function automatic int map_sample(input logic [7:0] d);
`ifdef VU_SIGNED_INPUT_EN
    int v;
    v = $signed(d);
    if (v < 0) v = -v;
    if (v > 127) v = 127;
    return v * 2;
`else
    return int'(d);
`endif
  endfunction

  function automatic logic [NS-1:0] therm(input int lvl);
    int n;
    n = (lvl == 0) ? 0 : ((lvl - 1) / (256 / NS)) + 1;
    return NS'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_level = 0; m_peak = 0; m_hold_left = 0; m_stb = 0;
    m_holding = 0; m_falling = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit t);
    int s, dl, ln, p;
    s  = v ? map_sample(d) : 0;
    dl = t ? ((m_level > DEC) ? m_level - DEC : 0) : m_level;
    ln = (dl > s) ? dl : s;
    m_stb = 0;
    if (v && s >= m_peak && s != 0) begin
      m_peak = s; m_hold_left = HOLDT; m_holding = 1; m_falling = 0; m_stb = 1;
    end else if (m_holding) begin
      if (t) begin
        m_hold_left--;
        if (m_hold_left == 0) begin m_holding = 0; m_falling = 1; end
      end
    end else if (m_falling) begin
      if (t) begin
        p = (m_peak > PST) ? m_peak - PST : 0;
        m_peak = (p > ln) ? p : ln;
        if (m_peak == ln && ln == 0) m_falling = 0;
      end
    end else begin
      m_peak = ln;
    end
    m_level = ln;
  endtask

  task automatic do_cycle(input bit v, input logic [7:0] d, input bit t);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.tick     = t;
    model_step(v, d, t);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tick     = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bit stb_seen;
    stb_seen = 0;
    do_cycle(0, 8'h00, 1);
    if (bus.peak_stb) stb_seen = 1;
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 8'h00, 0);
      if (bus.peak_stb) stb_seen = 1;
    end
    tests_run++;
    if (bus.level !== 8'h00) begin tests_failed++; $display("FAIL reset_level: got %0h want 0", bus.level); end
    tests_run++;
    if (bus.peak !== 8'h00) begin tests_failed++; $display("FAIL reset_peak: got %0h want 0", bus.peak); end
    tests_run++;
    if (bus.segs !== '0) begin tests_failed++; $display("FAIL reset_segs: got %0h want 0", bus.segs); end
    tests_run++;
    if (stb_seen) begin tests_failed++; $display("FAIL reset_stb: peak_stb asserted with no samples"); end
  endtask

  task automatic test_capture();
    do_cycle(1, 8'h59, 0);
    tests_run++;
    if (bus.level !== 8'h59) begin tests_failed++; $display("FAIL cap_level: got %0h want 59", bus.level); end
    tests_run++;
    if (bus.peak !== 8'h59) begin tests_failed++; $display("FAIL cap_peak: got %0h want 59", bus.peak); end
    tests_run++;
    if (bus.segs !== 8'h07) begin tests_failed++; $display("FAIL cap_segs: got %0h want 07", bus.segs); end
    tests_run++;
    if (bus.peak_stb !== 1'b1) begin tests_failed++; $display("FAIL cap_stb: got %0b want 1", bus.peak_stb); end
    do_cycle(0, 8'h00, 0);
    tests_run++;
    if (bus.peak_stb !== 1'b0) begin tests_failed++; $display("FAIL cap_stb_width: got %0b want 0", bus.peak_stb); end
    for (int i = 0; i < 5; i++) do_cycle(0, 8'h00, 1);
    tests_run++;
    if (bus.level !== 8'h45) begin tests_failed++; $display("FAIL decay5_level: got %0h want 45", bus.level); end
    tests_run++;
    if (bus.peak !== 8'h59) begin tests_failed++; $display("FAIL hold_peak: got %0h want 59", bus.peak); end
  endtask

  task automatic test_hold_fall();
    int exp_l, exp_p;
    do_cycle(1, 8'hBA, 0);
    for (int i = 1; i <= 33; i++) begin
      do_cycle(0, 8'h00, 1);
      exp_l = 'hBA - 4 * i;
      exp_p = (i <= 30) ? 'hBA : 'hBA - 2 * (i - 30);
      tests_run++;
      if (bus.level !== 8'(exp_l)) begin tests_failed++; $display("FAIL hf_level[%0d]: got %0h want %0h", i, bus.level, exp_l); end
      tests_run++;
      if (bus.peak !== 8'(exp_p)) begin tests_failed++; $display("FAIL hf_peak[%0d]: got %0h want %0h", i, bus.peak, exp_p); end
      tests_run++;
      if (bus.peak < bus.level) begin tests_failed++; $display("FAIL hf_invariant[%0d]: peak %0h below level %0h", i, bus.peak, bus.level); end
    end
  endtask

  task automatic test_coincident();
    apply_reset();
    do_cycle(1, 8'h40, 0);
    do_cycle(1, 8'h10, 1);
    tests_run++;
    if (bus.level !== 8'h3C) begin tests_failed++; $display("FAIL coincide_level: got %0h want 3c", bus.level); end
    do_cycle(1, 8'h01, 0);
    tests_run++;
    if (bus.level !== 8'h3C) begin tests_failed++; $display("FAIL no_tick_no_decay: got %0h want 3c", bus.level); end
    do_cycle(1, 8'h40, 0);
    tests_run++;
    if (bus.peak_stb !== 1'b1) begin tests_failed++; $display("FAIL recapture_stb: got %0b want 1", bus.peak_stb); end
    apply_reset();
    do_cycle(1, 8'h03, 0);
    do_cycle(0, 8'h00, 1);
    tests_run++;
    if (bus.level !== 8'h00) begin tests_failed++; $display("FAIL sat_level: got %0h want 0", bus.level); end
    tests_run++;
    if (bus.segs !== 8'h00) begin tests_failed++; $display("FAIL sat_segs: got %0h want 0", bus.segs); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_cycle(1, 8'hBF, 0);
    do_cycle(0, 8'h00, 1);
    do_cycle(0, 8'h00, 1);
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.level, bus.peak, bus.segs, bus.peak_stb} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: level %0h peak %0h segs %0h stb %0b want all 0", bus.level, bus.peak, bus.segs, bus.peak_stb);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    do_cycle(1, 8'h59, 0);
    tests_run++;
    if (bus.peak !== 8'h59 || bus.peak_stb !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_capture: peak %0h stb %0b want 59/1", bus.peak, bus.peak_stb);
    end
  endtask

`ifdef VU_SIGNED_INPUT_EN
  task automatic test_signed();
    logic [7:0] ins [3];
    logic [7:0] outs [3];
    ins  = '{8'h80, 8'h59, 8'hFF};
    outs = '{8'hFE, 8'hB2, 8'h02};
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      do_cycle(1, ins[i], 0);
      tests_run++;
      if (bus.level !== outs[i]) begin tests_failed++; $display("FAIL signed_map[%0h]: got %0h want %0h", ins[i], bus.level, outs[i]); end
    end
  endtask
`endif

  task automatic test_random();
    bit v, t;
    logic [7:0] d;
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      if ((c / 500) % 2 == 1) d = d >> 3;
      do_cycle(v, d, t);
      tests_run++;
      if (bus.level !== 8'(m_level)) begin tests_failed++; $display("FAIL rnd_level@%0d: got %0h want %0h", c, bus.level, m_level); end
      tests_run++;
      if (bus.peak !== 8'(m_peak)) begin tests_failed++; $display("FAIL rnd_peak@%0d: got %0h want %0h", c, bus.peak, m_peak); end
      tests_run++;
      if (bus.segs !== therm(m_level)) begin tests_failed++; $display("FAIL rnd_segs@%0d: got %0h want %0h", c, bus.segs, therm(m_level)); end
      tests_run++;
      if (bus.peak_stb !== 1'(m_stb)) begin tests_failed++; $display("FAIL rnd_stb@%0d: got %0b want %0b", c, bus.peak_stb, m_stb); end
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tick     = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.level, bus.peak, bus.segs, bus.peak_stb} !== '0) begin
      tests_failed++;
      $display("FAIL in_reset: level %0h peak %0h segs %0h stb %0b want all 0", bus.level, bus.peak, bus.segs, bus.peak_stb);
    end
    rst = 1'b0;
    test_reset();
    test_capture();
    test_hold_fall();
    test_coincident();
    test_async_reset();
`ifdef VU_SIGNED_INPUT_EN
    test_signed();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
